// File: rtl/mdu_pkg.sv
// Shared types and constants for the MDU divider.
package mdu_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Operand combinations that bypass the iterative datapath.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    DIVZ = 2'd1,
    OVF  = 2'd2
  } div_special_e;

  // Leading-zero skip widths, tried largest first.
  localparam int unsigned DIV_SKIP_16 = 16;
  localparam int unsigned DIV_SKIP_8  = 8;
  localparam int unsigned DIV_SKIP_4  = 4;
  localparam int unsigned DIV_NUM_SKIPS = 3;

  // Skip width for priority slot idx (0 = widest).
  function automatic int unsigned div_skip_bits(input int unsigned idx);
    case (idx)
      0:       return DIV_SKIP_16;
      1:       return DIV_SKIP_8;
      default: return DIV_SKIP_4;
    endcase
  endfunction

endpackage

// File: rtl/div_r4_step.sv
// One radix-4 restoring-division step: shifts two dividend bits into the
// partial remainder, trial-subtracts 1D/2D/3D and keeps the largest that fits.
module div_r4_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  // 4R + two bits and 3D both fit in WIDTH+2 bits.
  localparam int EXT_W = WIDTH + 2;

  logic [EXT_W-1:0]        rem_shift;
  logic [3:1][EXT_W-1:0]   mult;
  logic [3:1]              fits;
  logic [1:0]              digit;
  logic [WIDTH-1:0]        sub_val;

  assign rem_shift = {rem, q[WIDTH-1:WIDTH-2]};

  genvar gi;
  generate
    for (gi = 1; gi <= 3; gi++) begin : g_trial
      assign mult[gi] = EXT_W'(gi) * {2'b00, divisor};
      assign fits[gi] = (rem_shift >= mult[gi]);
    end
  endgenerate

  // Quotient-digit select: largest multiple that does not exceed the shifted remainder.
  always_comb begin
    digit   = 2'd0;
    sub_val = '0;
    if (fits[3]) begin
      digit   = 2'd3;
      sub_val = mult[3][WIDTH-1:0];
    end else if (fits[2]) begin
      digit   = 2'd2;
      sub_val = mult[2][WIDTH-1:0];
    end else if (fits[1]) begin
      digit   = 2'd1;
      sub_val = mult[1][WIDTH-1:0];
    end
  end

  // The true difference is below the divisor, so WIDTH-bit wraparound is exact.
  assign rem_next = rem_shift[WIDTH-1:0] - sub_val;
  assign q_next   = {q[WIDTH-3:0], digit};

endmodule

// File: rtl/radix4_divider.sv
// Iterative radix-4 signed/unsigned divider with optional leading-zero skip,
// valid/ready handshakes on request and result, tag passthrough and flush.
module radix4_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 6,
  parameter int EARLY_SKIP = 1
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             flush_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_reg, state_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic [WIDTH-1:0] quot_out_reg, quot_out_next;
  logic [WIDTH-1:0] rem_out_reg, rem_out_next;
  logic [TAG_W-1:0] tag_out_reg, tag_out_next;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  div_special_e     special;

  logic [WIDTH-1:0] step_rem, step_q;
  logic [WIDTH-1:0] calc_rem, calc_q;
  logic [CNT_W-1:0] calc_cnt;

  logic [DIV_NUM_SKIPS-1:0]             skip_ok;
  logic [DIV_NUM_SKIPS-1:0][WIDTH-1:0] skip_rem;
  logic [DIV_NUM_SKIPS-1:0][WIDTH-1:0] skip_q;
  logic [DIV_NUM_SKIPS-1:0][CNT_W-1:0] skip_cnt;

  // Handshake: requests are taken when idle or when the held result drains this cycle.
  assign div_ready_o = ~flush_i & ((state_reg == DIV_IDLE) |
                                   ((state_reg == DIV_DONE) & res_ready_i));
  assign accept      = div_valid_i & div_ready_o;
  assign res_valid_o = (state_reg == DIV_DONE);
  assign quotient_o  = quot_out_reg;
  assign remainder_o = rem_out_reg;
  assign tag_o       = tag_out_reg;

  // Operand conditioning: magnitudes for the unsigned core, plus bypass detection.
  assign a_neg = div_signed_i & dividend_i[WIDTH-1];
  assign b_neg = div_signed_i & divisor_i[WIDTH-1];
  assign a_mag = a_neg ? (-dividend_i) : dividend_i;
  assign b_mag = b_neg ? (-divisor_i) : divisor_i;

  // Classify the incoming request; divide-by-zero wins over overflow.
  always_comb begin
    special = NONE;
    if (divisor_i == '0) begin
      special = DIVZ;
    end else if (div_signed_i && (dividend_i == MIN_VAL) && (divisor_i == '1)) begin
      special = OVF;
    end
  end

  div_r4_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .q        (q_reg),
    .divisor  (dvs_reg),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  // A skip of k is legal when the remainder with the next k dividend bits is
  // still below the divisor: all k quotient bits are then zero.
  genvar gi;
  generate
    for (gi = 0; gi < DIV_NUM_SKIPS; gi++) begin : g_skip
      localparam int K = int'(div_skip_bits(gi));
      if (K <= WIDTH) begin : g_on
        assign skip_ok[gi]  = (EARLY_SKIP != 0) && (cnt_reg >= CNT_W'(K)) &&
                              ({rem_reg, q_reg[WIDTH-1 -: K]} < {{K{1'b0}}, dvs_reg});
        assign skip_rem[gi] = WIDTH'({rem_reg, q_reg[WIDTH-1 -: K]});
        assign skip_q[gi]   = q_reg << K;
        assign skip_cnt[gi] = cnt_reg - CNT_W'(K);
      end else begin : g_off
        assign skip_ok[gi]  = 1'b0;
        assign skip_rem[gi] = '0;
        assign skip_q[gi]   = '0;
        assign skip_cnt[gi] = '0;
      end
    end
  endgenerate

  // One CALC action per cycle: widest legal skip first, otherwise a radix-4 step.
  always_comb begin
    calc_rem = step_rem;
    calc_q   = step_q;
    calc_cnt = cnt_reg - CNT_W'(2);
    if (skip_ok[0]) begin
      calc_rem = skip_rem[0];
      calc_q   = skip_q[0];
      calc_cnt = skip_cnt[0];
    end else if (skip_ok[1]) begin
      calc_rem = skip_rem[1];
      calc_q   = skip_q[1];
      calc_cnt = skip_cnt[1];
    end else if (skip_ok[2]) begin
      calc_rem = skip_rem[2];
      calc_q   = skip_q[2];
      calc_cnt = skip_cnt[2];
    end
  end

  // Next-state and datapath update; flush overrides everything else.
  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    q_next        = q_reg;
    dvs_next      = dvs_reg;
    cnt_next      = cnt_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    tag_next      = tag_reg;
    quot_out_next = quot_out_reg;
    rem_out_next  = rem_out_reg;
    tag_out_next  = tag_out_reg;

    case (state_reg)
      DIV_IDLE: ;
      DIV_CALC: begin
        rem_next = calc_rem;
        q_next   = calc_q;
        cnt_next = calc_cnt;
        if (calc_cnt == '0) begin
          // Sign fix-up is folded into the registered result.
          state_next    = DIV_DONE;
          quot_out_next = neg_q_reg ? (-calc_q) : calc_q;
          rem_out_next  = neg_r_reg ? (-calc_rem) : calc_rem;
          tag_out_next  = tag_reg;
        end
      end
      DIV_DONE: begin
        if (res_ready_i) state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase

    if (accept) begin
      rem_next   = '0;
      q_next     = a_mag;
      dvs_next   = b_mag;
      cnt_next   = CNT_W'(WIDTH);
      neg_q_next = a_neg ^ b_neg;
      neg_r_next = a_neg;
      tag_next   = tag_i;
      case (special)
        DIVZ: begin
          state_next    = DIV_DONE;
          quot_out_next = '1;
          rem_out_next  = dividend_i;
          tag_out_next  = tag_i;
        end
        OVF: begin
          state_next    = DIV_DONE;
          quot_out_next = MIN_VAL;
          rem_out_next  = '0;
          tag_out_next  = tag_i;
        end
        default: state_next = DIV_CALC;
      endcase
    end

    if (flush_i) state_next = DIV_IDLE;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!a_rst_n) begin
      state_reg    <= DIV_IDLE;
      rem_reg      <= '0;
      q_reg        <= '0;
      dvs_reg      <= '0;
      cnt_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      tag_reg      <= '0;
      quot_out_reg <= '0;
      rem_out_reg  <= '0;
      tag_out_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      q_reg        <= q_next;
      dvs_reg      <= dvs_next;
      cnt_reg      <= cnt_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      tag_reg      <= tag_next;
      quot_out_reg <= quot_out_next;
      rem_out_reg  <= rem_out_next;
      tag_out_reg  <= tag_out_next;
    end
  end

endmodule

// File: tb/tb_radix4_divider.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// arithmetic reference model. Instance dut1 has leading-zero skip, dut0 does not.
module tb_radix4_divider;

  localparam int W  = 32;
  localparam int TW = 6;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n, flush, div_valid, div_signed, res_ready;
  logic [W-1:0]  dividend, divisor;
  logic [TW-1:0] tag;

  logic          div_ready0, res_valid0, div_ready1, res_valid1;
  logic [W-1:0]  quotient0, remainder0, quotient1, remainder1;
  logic [TW-1:0] tag_o0, tag_o1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  radix4_divider #(.WIDTH(W), .TAG_W(TW), .EARLY_SKIP(0)) dut0 (
    .clk(clk), .a_rst_n(rst_n), .flush_i(flush),
    .div_valid_i(div_valid), .div_ready_o(div_ready0), .div_signed_i(div_signed),
    .dividend_i(dividend), .divisor_i(divisor), .tag_i(tag),
    .res_valid_o(res_valid0), .res_ready_i(res_ready),
    .quotient_o(quotient0), .remainder_o(remainder0), .tag_o(tag_o0)
  );

  radix4_divider #(.WIDTH(W), .TAG_W(TW), .EARLY_SKIP(1)) dut1 (
    .clk(clk), .a_rst_n(rst_n), .flush_i(flush),
    .div_valid_i(div_valid), .div_ready_o(div_ready1), .div_signed_i(div_signed),
    .dividend_i(dividend), .divisor_i(divisor), .tag_i(tag),
    .res_valid_o(res_valid1), .res_ready_i(res_ready),
    .quotient_o(quotient1), .remainder_o(remainder1), .tag_o(tag_o1)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend's sign.
  function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    logic signed [W-1:0] sa, sb_v;
    sa   = a;
    sb_v = b;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn && a == MIN_V && b == '1) begin
      q = MIN_V;
      r = '0;
    end else if (sgn) begin
      q = sa / sb_v;
      r = sa % sb_v;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one op to both instances with res_ready high, capture each result and its latency.
  task automatic do_op(input string name, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tg, input int exp_lat1);
    logic [W-1:0]  eq, er, q0, r0, q1, r1;
    logic [TW-1:0] t0, t1;
    int lat0, lat1, exp_lat0;
    bit special;
    ref_div(sgn, a, b, eq, er);
    special  = (b == 0) || (sgn && a == MIN_V && b == '1);
    exp_lat0 = special ? 1 : (W / 2 + 1);
    @(posedge clk); #1;
    div_valid = 1'b1; div_signed = sgn; dividend = a; divisor = b; tag = tg; res_ready = 1'b1;
    @(negedge clk);
    check({name, " ready0"}, 64'(div_ready0), 64'(1));
    check({name, " ready1"}, 64'(div_ready1), 64'(1));
    @(posedge clk); #1;
    div_valid = 1'b0;
    lat0 = -1; lat1 = -1;
    q0 = 'x; r0 = 'x; t0 = 'x; q1 = 'x; r1 = 'x; t1 = 'x;
    for (int c = 1; c <= 40 && (lat0 < 0 || lat1 < 0); c++) begin
      @(negedge clk);
      if (lat0 < 0 && res_valid0) begin lat0 = c; q0 = quotient0; r0 = remainder0; t0 = tag_o0; end
      if (lat1 < 0 && res_valid1) begin lat1 = c; q1 = quotient1; r1 = remainder1; t1 = tag_o1; end
      if (lat0 < 0 || lat1 < 0) @(posedge clk);
    end
    check({name, " q0"}, 64'(q0), 64'(eq));
    check({name, " r0"}, 64'(r0), 64'(er));
    check({name, " tag0"}, 64'(t0), 64'(tg));
    check({name, " lat0"}, 64'(lat0), 64'(exp_lat0));
    check({name, " q1"}, 64'(q1), 64'(eq));
    check({name, " r1"}, 64'(r1), 64'(er));
    check({name, " tag1"}, 64'(t1), 64'(tg));
    if (special)
      check({name, " lat1"}, 64'(lat1), 64'(1));
    else if (exp_lat1 >= 0)
      check({name, " lat1"}, 64'(lat1), 64'(exp_lat1));
    else
      check({name, " lat1 bound"}, 64'(lat1 >= 1 && lat1 <= W / 2 + 1), 64'(1));
    $display("op %s: sgn=%0d a=%h b=%h -> q=%h r=%h lat0=%0d lat1=%0d",
             name, sgn, a, b, q1, r1, lat0, lat1);
  endtask

  // Start an op without waiting for it (used before flush/reset aborts).
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tg);
    @(posedge clk); #1;
    div_valid = 1'b1; div_signed = sgn; dividend = a; divisor = b; tag = tg;
    @(posedge clk); #1;
    div_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] eq, er;
    exp_t e;
    int n_ops, pend, vcount;
    bit exp_rdy;

    rst_n = 1'b0; flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0; tag = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst valid", 64'(res_valid1), 64'(0));
    check("rst q", 64'(quotient1), 64'(0));
    check("rst r", 64'(remainder1), 64'(0));
    check("rst tag", 64'(tag_o1), 64'(0));
    check("rst ready1", 64'(div_ready1), 64'(1));
    check("rst ready0", 64'(div_ready0), 64'(1));

    // Basic, signed and special-case ops
    do_op("100/7", 1'b0, 32'd100, 32'd7, 6'd1, -1);
    do_op("-5/3", 1'b1, -32'sd5, 32'd3, 6'd2, -1);
    do_op("5/-3", 1'b1, 32'd5, -32'sd3, 6'd3, -1);
    do_op("-5/-3", 1'b1, -32'sd5, -32'sd3, 6'd4, -1);
    do_op("min/-1", 1'b1, MIN_V, 32'hFFFF_FFFF, 6'd5, -1);
    do_op("1234/0 s", 1'b1, 32'd1234, 32'd0, 6'd6, -1);
    do_op("1234/0 u", 1'b0, 32'd1234, 32'd0, 6'd7, -1);
    do_op("1/1", 1'b0, 32'd1, 32'd1, 6'd8, 6);
    do_op("min/3 s", 1'b1, MIN_V, 32'd3, 6'd9, -1);
    do_op("max/1 u", 1'b0, 32'hFFFF_FFFF, 32'd1, 6'd10, -1);

    // Backpressure: result held stable, no new request accepted
    ref_div(1'b1, -32'sd1000, 32'd7, eq, er);
    @(posedge clk); #1;
    res_ready = 1'b0;
    issue(1'b1, -32'sd1000, 32'd7, 6'd11);
    for (int c = 0; c < 40 && !(res_valid0 && res_valid1); c++) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold valid", 64'(res_valid1), 64'(1));
      check("hold q", 64'(quotient1), 64'(eq));
      check("hold r", 64'(remainder1), 64'(er));
      check("hold tag", 64'(tag_o1), 64'(11));
      check("hold ready", 64'(div_ready1), 64'(0));
      @(posedge clk);
    end
    $display("op hold: q=%h r=%h tag=%0d held 10 cycles", quotient1, remainder1, tag_o1);
    // Drain and accept in the same cycle
    #1;
    res_ready = 1'b1; div_valid = 1'b1; div_signed = 1'b0;
    dividend = 32'd1234; divisor = 32'd0; tag = 6'd12;
    @(negedge clk);
    check("b2b ready1", 64'(div_ready1), 64'(1));
    check("b2b ready0", 64'(div_ready0), 64'(1));
    @(posedge clk); #1;
    div_valid = 1'b0;
    @(negedge clk);
    check("b2b valid", 64'(res_valid1), 64'(1));
    check("b2b tag", 64'(tag_o1), 64'(12));
    check("b2b q", 64'(quotient1), 64'(32'hFFFF_FFFF));
    check("b2b r", 64'(remainder1), 64'(1234));
    $display("op b2b: tag=%0d q=%h r=%h", tag_o1, quotient1, remainder1);
    @(posedge clk);

    // Flush mid-CALC
    issue(1'b0, 32'h1234_5678, 32'd3, 6'd13);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush ready", 64'(div_ready1), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush valid", 64'(res_valid1), 64'(0));
    check("flush ready after", 64'(div_ready1), 64'(1));
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid1 || res_valid0) vcount++;
    end
    check("flush no result", 64'(vcount), 64'(0));
    $display("op flush: aborted op produced %0d result cycles", vcount);

    // Reset mid-CALC
    issue(1'b0, 32'h1234_5678, 32'd3, 6'd14);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2 valid", 64'(res_valid1), 64'(0));
    check("rst2 ready", 64'(div_ready1), 64'(1));
    check("rst2 q", 64'(quotient1), 64'(0));
    check("rst2 tag", 64'(tag_o1), 64'(0));
    $display("op reset: valid=%0d ready=%0d", res_valid1, div_ready1);
    do_op("ffffffff/10", 1'b0, 32'hFFFF_FFFF, 32'h10, 6'd15, -1);

    // Randomized traffic on the skipping instance
    n_ops = 0;
    pend  = 0;
    for (int cyc = 0; cyc < 80000 && n_ops < 2000; cyc++) begin
      @(posedge clk); #1;
      flush      = ($urandom_range(0, 63) == 0);
      res_ready  = ($urandom_range(0, 3) != 0);
      div_valid  = ($urandom_range(0, 2) != 0);
      div_signed = 1'($urandom_range(0, 1));
      dividend   = $urandom >> $urandom_range(0, 31);
      divisor    = $urandom >> $urandom_range(0, 31);
      tag        = TW'($urandom);
      case ($urandom_range(0, 15))
        0: divisor = '0;
        1: begin div_signed = 1'b1; dividend = MIN_V; divisor = '1; end
        2: dividend = $urandom;
        default: ;
      endcase
      @(negedge clk);
      exp_rdy = !flush && (sb.size() == 0 || (res_valid1 && res_ready));
      check("rnd ready", 64'(div_ready1), 64'(exp_rdy));
      if (sb.size() == 0) begin
        check("rnd spurious valid", 64'(res_valid1), 64'(0));
      end else if (res_valid1 && res_ready && !flush) begin
        e = sb.pop_front();
        check("rnd q", 64'(quotient1), 64'(e.q));
        check("rnd r", 64'(remainder1), 64'(e.r));
        check("rnd tag", 64'(tag_o1), 64'(e.t));
        pend = 0;
      end else if (!res_valid1) begin
        pend++;
        if (pend > W / 2 + 2) begin
          check("rnd latency", 64'(pend), 64'(W / 2 + 1));
          sb.delete();
          pend = 0;
        end
      end
      if (flush) begin
        sb.delete();
        pend = 0;
      end
      if (div_valid && exp_rdy) begin
        ref_div(div_signed, dividend, divisor, e.q, e.r);
        e.t = tag;
        sb.push_back(e);
        n_ops++;
        pend = 0;
      end
    end
    check("rnd ops completed", 64'(n_ops >= 2000), 64'(1));
    $display("random: %0d ops accepted", n_ops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
